riscv_core_immgen_stage: RTL
============================

Name: riscv_core_immgen_stage

Overview:
Registered immediate-generation pipeline stage for the RV32I/RV64I core, parametrised on XLEN.
- Takes the full 32-bit instruction plus an explicit format select, or decodes the format itself from the opcode (auto mode).
- Produces the sign/zero-extended XLEN-bit immediate one cycle later, behind a valid/ready handshake with an optional skid buffer.
- Sits between fetch/decode and the register-read stage; it carries an opaque sideband tag (e.g. PC or ROB id) alongside each immediate.

Parameters:
- XLEN, 64, datapath width; legal values 32 or 64.
- TAG_W, 32, width of the sideband tag carried with each entry; minimum 1.
- SKID, 1, 1 = two-entry skid buffer with registered ready; 0 = single register with combinational ready.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_immgen_flush  in  1  synchronous pipeline flush.
- i_immgen_valid  in  1  upstream entry valid.
- o_immgen_ready  out  1  stage can accept an entry.
- i_immgen_instr  in  32  full instruction word.
- i_immgen_immsrc  in  3  format select: 000 I, 001 S, 010 B, 011 J, 100 U, 101 zero, 110 CSR zimm, 111 auto-decode.
- i_immgen_tag  in  TAG_W  sideband, passed through unchanged.
- o_immgen_valid  out  1  output entry valid.
- i_immgen_out_ready  in  1  downstream accepts the output entry.
- o_immgen_imm  out  XLEN  extended immediate.
- o_immgen_fmt  out  3  resolved format (000..110; never 111).
- o_immgen_illegal  out  1  auto mode only: opcode not recognised.
- o_immgen_tag  out  TAG_W  tag of the output entry.

Behaviour:
- Reset (async, i_rst=1):
  - o_immgen_valid=0.
  - o_immgen_imm, o_immgen_fmt, o_immgen_tag and o_immgen_illegal are all 0.
  - Skid entry is invalid.
  - o_immgen_ready=1 once reset deasserts (with SKID=0 it is also 1, because the stage is empty).
- Reset mid-transfer discards all held entries.
- Handshake:
  - Input fires when i_immgen_valid and o_immgen_ready are both 1.
  - Output fires when o_immgen_valid and i_immgen_out_ready are both 1.
  - Held output data must stay stable while o_immgen_valid=1 and i_immgen_out_ready=0.
- Latency 1 cycle (input fire to o_immgen_valid); throughput 1 entry per cycle.
- SKID=1:
  - o_immgen_ready is registered and equals NOT skid_valid.
  - Entry accepted while the main register is full and the output stalls goes into the skid register; ready drops the next cycle.
  - When the output fires, the skid entry moves into the main register.
  - Entries leave in strict order: no loss, no duplication.
- SKID=0: o_immgen_ready = NOT main_valid OR i_immgen_out_ready.
- Flush:
  - Clears main and skid valid on the next edge.
  - An input firing in the same cycle is dropped.
  - Flush has priority over every other event.
  - o_immgen_ready=1 the following cycle.
- Extension rules (instr = i_immgen_instr; sign bit = instr[31]; sign-extend to XLEN):
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - U: {instr[31:12], 12'b0}; sign-extended only when XLEN=64.
  - zero: all bits 0.
  - CSR zimm: zero-extended instr[19:15].
- Auto-decode (immsrc=111) on opcode instr[6:0]:
  - 0010011, 0000011, 1100111, 0001111 -> I.
  - 0011011 -> I when XLEN=64; illegal when XLEN=32.
  - 0100011 -> S.
  - 1100011 -> B.
  - 1101111 -> J.
  - 0110111, 0010111 -> U.
  - 1110011 with funct3[2]=1 -> CSR zimm; with funct3[2]=0 -> I.
  - 0110011 -> zero; 0111011 -> zero (XLEN=64), illegal (XLEN=32).
  - Anything else -> zero, and o_immgen_illegal=1.
- o_immgen_illegal is always 0 for explicit immsrc.

Decomposition:
- Package riscv_core_imm_pkg:
  - immsrc encodings IMM_I..IMM_ZIMM and IMM_AUTO.
  - Opcode constants.
  - A function resolving opcode plus XLEN to {fmt, illegal}.
- Sub-module riscv_core_immgen_comb (parameter XLEN): purely combinational format-to-immediate extender, instantiated once before the pipeline registers.
- The stage module itself owns the auto-decode mux, main/skid registers, handshake and flush.

Test Plan:
1. XLEN=64, instr 0xFFF00093 (addi x1,x0,-1), immsrc 000 -> next cycle valid=1, imm 0xFFFFFFFFFFFFFFFF, fmt 000.
2. Auto, instr 0xFE000EE3 (beq x0,x0,-4) -> imm 0xFFFFFFFFFFFFFFFC, fmt 010, illegal 0.
3. Auto, instr 0x800000B7 (lui) -> XLEN=64: 0xFFFFFFFF80000000; XLEN=32: 0x80000000. Auto, instr 0x300FD073 (csrrwi) -> imm 0x1F, fmt 110.
4. SKID=1, out_ready=0, three back-to-back valid entries (tags 1,2,3):
   - Tags 1 and 2 are accepted and ready drops; tag 3 is held upstream.
   - Raise out_ready -> tags 1,2,3 emerge on consecutive output fires, in order, with no duplicates.
5. Main and skid both full, assert flush together with a valid input -> next cycle o_immgen_valid=0, ready=1, and the flushed input never appears at the output.
6. Auto, instr 0x0000007F -> imm 0, illegal 1. XLEN=32, instr 0x0000001B -> illegal 1. Assert i_rst mid-stall -> valid=0 immediately (asynchronously).

Source files
------------

// File: rtl/riscv_core_imm_pkg.sv
// riscv_core_imm_pkg: immediate format encodings, opcodes and opcode-to-format resolution
package riscv_core_imm_pkg;
    localparam logic [2:0] IMM_I    = 3'b000;
    localparam logic [2:0] IMM_S    = 3'b001;
    localparam logic [2:0] IMM_B    = 3'b010;
    localparam logic [2:0] IMM_J    = 3'b011;
    localparam logic [2:0] IMM_U    = 3'b100;
    localparam logic [2:0] IMM_ZERO = 3'b101;
    localparam logic [2:0] IMM_ZIMM = 3'b110;
    localparam logic [2:0] IMM_AUTO = 3'b111;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;

    // Returns {fmt, illegal}; the 32-bit-word opcodes are only legal on RV64.
    function automatic logic [3:0] resolve_fmt(input logic [6:0] op, input logic f3_msb, input int xlen);
        logic [3:0] r;
        logic rv64;
        rv64 = (xlen == 64);
        case (op)
            OP_IMM, OP_LOAD, OP_JALR, OP_FENCE: r = {IMM_I, 1'b0};
            OP_IMM32:                           r = rv64 ? {IMM_I, 1'b0} : {IMM_ZERO, 1'b1};
            OP_STORE:                           r = {IMM_S, 1'b0};
            OP_BRANCH:                          r = {IMM_B, 1'b0};
            OP_JAL:                             r = {IMM_J, 1'b0};
            OP_LUI, OP_AUIPC:                   r = {IMM_U, 1'b0};
            OP_SYSTEM:                          r = {f3_msb ? IMM_ZIMM : IMM_I, 1'b0};
            OP_REG:                             r = {IMM_ZERO, 1'b0};
            OP_REG32:                           r = {IMM_ZERO, !rv64};
            default:                            r = {IMM_ZERO, 1'b1};
        endcase
        return r;
    endfunction
endpackage

// File: rtl/riscv_core_immgen_comb.sv
// riscv_core_immgen_comb: combinational format-to-immediate extender
module riscv_core_immgen_comb
    import riscv_core_imm_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      fmt,
    output logic [XLEN-1:0] imm
);
    logic [31:0] imm32;

    // Build the 32-bit immediate; zero and zimm have bit 31 clear so a plain sign extension covers every format.
    always_comb begin
        imm32 = fmt == IMM_I    ? {{20{instr[31]}}, instr[31:20]} :
                fmt == IMM_S    ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
                fmt == IMM_B    ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
                fmt == IMM_J    ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} :
                fmt == IMM_U    ? {instr[31:12], 12'b0} :
                fmt == IMM_ZIMM ? {27'b0, instr[19:15]} :
                                  32'b0;
    end

    assign imm = XLEN'($signed(imm32));
endmodule

// File: rtl/riscv_core_immgen_stage.sv
// riscv_core_immgen_stage: registered immediate generation with valid/ready handshake and optional skid buffer
module riscv_core_immgen_stage
    import riscv_core_imm_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int TAG_W = 32,
    parameter int SKID  = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_immgen_flush,
    input  logic             i_immgen_valid,
    output logic             o_immgen_ready,
    input  logic [31:0]      i_immgen_instr,
    input  logic [2:0]       i_immgen_immsrc,
    input  logic [TAG_W-1:0] i_immgen_tag,
    output logic             o_immgen_valid,
    input  logic             i_immgen_out_ready,
    output logic [XLEN-1:0]  o_immgen_imm,
    output logic [2:0]       o_immgen_fmt,
    output logic             o_immgen_illegal,
    output logic [TAG_W-1:0] o_immgen_tag
);
    logic [3:0]       dec;
    logic [2:0]       fmt_in;
    logic             ill_in;
    logic [XLEN-1:0]  imm_in;
    logic             skid_valid;
    logic [XLEN-1:0]  skid_imm;
    logic [2:0]       skid_fmt;
    logic             skid_ill;
    logic [TAG_W-1:0] skid_tag;
    logic             in_fire;
    logic             out_fire;
    logic             load_main;
    logic             load_skid;

    assign dec = resolve_fmt(i_immgen_instr[6:0], i_immgen_instr[14], XLEN);

    // Explicit selects pass straight through and are never illegal; auto mode uses the opcode decode.
    always_comb begin
        fmt_in = i_immgen_immsrc == IMM_AUTO ? dec[3:1] : i_immgen_immsrc;
        ill_in = i_immgen_immsrc == IMM_AUTO ? dec[0] : 1'b0;
    end

    riscv_core_immgen_comb #(.XLEN(XLEN)) u_ext (
        .instr (i_immgen_instr),
        .fmt   (fmt_in),
        .imm   (imm_in)
    );

    assign o_immgen_ready = SKID != 0 ? !skid_valid : (!o_immgen_valid || i_immgen_out_ready);
    assign in_fire        = i_immgen_valid && o_immgen_ready;
    assign out_fire       = o_immgen_valid && i_immgen_out_ready;
    assign load_main      = !o_immgen_valid || out_fire;
    assign load_skid      = SKID != 0 && in_fire && o_immgen_valid && !out_fire;

    // Occupancy: the skid entry refills main first, so an input can only reach main when skid is empty.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_immgen_valid <= 1'b0;
            skid_valid     <= 1'b0;
        end else if (i_immgen_flush) begin
            o_immgen_valid <= 1'b0;
            skid_valid     <= 1'b0;
        end else begin
            if (load_main) o_immgen_valid <= skid_valid || in_fire;
            if (load_skid) skid_valid <= 1'b1;
            else if (out_fire) skid_valid <= 1'b0;
        end
    end

    // Payload registers only change when a new entry lands, keeping stalled output data stable.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_immgen_imm     <= '0;
            o_immgen_fmt     <= '0;
            o_immgen_illegal <= 1'b0;
            o_immgen_tag     <= '0;
            skid_imm         <= '0;
            skid_fmt         <= '0;
            skid_ill         <= 1'b0;
            skid_tag         <= '0;
        end else begin
            if (load_main && (skid_valid || in_fire)) begin
                o_immgen_imm     <= skid_valid ? skid_imm : imm_in;
                o_immgen_fmt     <= skid_valid ? skid_fmt : fmt_in;
                o_immgen_illegal <= skid_valid ? skid_ill : ill_in;
                o_immgen_tag     <= skid_valid ? skid_tag : i_immgen_tag;
            end
            if (load_skid) begin
                skid_imm <= imm_in;
                skid_fmt <= fmt_in;
                skid_ill <= ill_in;
                skid_tag <= i_immgen_tag;
            end
        end
    end
endmodule
